// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshots systolic array results after a fixed latency and streams them row-major
// Define RESULT_DRAIN_SAT_EN for saturating ACC_W->OUT_W conversion and the sat_seen flag.
module systolic_result_drain #(
   parameter int WIDTH   = 16,
   parameter int SIZE    = 10,
   parameter int ACC_W   = 2*WIDTH + $clog2(SIZE) + 1,
   parameter int OUT_W   = 16,
   parameter int LATENCY = 3*SIZE - 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [ACC_W-1:0]  result_matrix [0:SIZE-1][0:SIZE-1],
   output logic                     busy,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [OUT_W-1:0]  m_data,
   output logic [$clog2(SIZE)-1:0]  m_row,
   output logic [$clog2(SIZE)-1:0]  m_col,
   output logic                     m_last,
   output logic                     done
`ifdef RESULT_DRAIN_SAT_EN
   ,
   output logic                     sat_seen
`endif
);

   localparam int IW = $clog2(SIZE);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

   typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, STREAM, DONE} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt;
   logic signed [OUT_W-1:0] conv [SIZE][SIZE];
   logic signed [OUT_W-1:0] snap [SIZE][SIZE];
   logic [IW-1:0]           nxt_row, nxt_col;

`ifdef RESULT_DRAIN_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   logic clamp      [SIZE][SIZE];
   logic snap_clamp [SIZE][SIZE];

   always_comb begin
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            clamp[r][c] = 1'b1;
            if (result_matrix[r][c] > MAX_V) begin
               conv[r][c] = MAX_V[OUT_W-1:0];
            end else if (result_matrix[r][c] < MIN_V) begin
               conv[r][c] = MIN_V[OUT_W-1:0];
            end else begin
               conv[r][c]  = result_matrix[r][c][OUT_W-1:0];
               clamp[r][c] = 1'b0;
            end
         end
      end
   end
`else
   // Wrap mode keeps only the low OUT_W bits; the rest feed a sink so nothing dangles.
   logic unused_hi;

   always_comb begin
      unused_hi = 1'b0;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            conv[r][c] = result_matrix[r][c][OUT_W-1:0];
            unused_hi  = unused_hi ^ (^result_matrix[r][c]);
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WAIT;
         WAIT:    if (cnt <= CW'(1)) state_nxt = CAPTURE;
         CAPTURE: state_nxt = STREAM;
         STREAM:  if (m_ready && m_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      nxt_row = m_row;
      nxt_col = m_col + 1'b1;
      if (m_col == LAST_IDX) begin
         nxt_col = '0;
         nxt_row = m_row + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         m_data <= '0;
         m_row  <= '0;
         m_col  <= '0;
         m_last <= 1'b0;
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
               snap[r][c] <= '0;
`ifdef RESULT_DRAIN_SAT_EN
               snap_clamp[r][c] <= 1'b0;
`endif
            end
         end
`ifdef RESULT_DRAIN_SAT_EN
         sat_seen <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt <= CW'(LATENCY - 1);
`ifdef RESULT_DRAIN_SAT_EN
                  sat_seen <= 1'b0;
`endif
               end
            end
            WAIT: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            CAPTURE: begin
               // Element [0][0] goes straight to the output so valid rises on this edge.
               snap   <= conv;
               m_data <= conv[0][0];
               m_row  <= '0;
               m_col  <= '0;
               m_last <= (SIZE == 1);
`ifdef RESULT_DRAIN_SAT_EN
               snap_clamp <= clamp;
               sat_seen   <= sat_seen | clamp[0][0];
`endif
            end
            STREAM: begin
               if (m_ready && m_last) begin
                  m_last <= 1'b0;
               end else if (m_ready) begin
                  m_row  <= nxt_row;
                  m_col  <= nxt_col;
                  m_data <= snap[nxt_row][nxt_col];
                  m_last <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
`ifdef RESULT_DRAIN_SAT_EN
                  sat_seen <= sat_seen | snap_clamp[nxt_row][nxt_col];
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign m_valid = (state == STREAM);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - directed self-checking bench for systolic_result_drain
`timescale 1ns/1ps
module tb_systolic_result_drain;

   localparam int WIDTH = 16;
   localparam int SIZE  = 10;
   localparam int ACC_W = 2*WIDTH + $clog2(SIZE) + 1;
   localparam int OUT_W = 16;
   localparam int LAT   = 3*SIZE - 2;
   localparam int IW    = $clog2(SIZE);
   localparam int NEL   = SIZE*SIZE;

   logic clk = 1'b0;
   logic reset, start, m_ready;
   logic busy, m_valid, m_last, done;
   logic signed [ACC_W-1:0] rm [0:SIZE-1][0:SIZE-1];
   logic signed [OUT_W-1:0] m_data;
   logic [IW-1:0] m_row, m_col;
`ifdef RESULT_DRAIN_SAT_EN
   logic sat_seen;
`endif

   int exp_d [0:SIZE-1][0:SIZE-1];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   systolic_result_drain #(
      .WIDTH(WIDTH), .SIZE(SIZE), .ACC_W(ACC_W), .OUT_W(OUT_W), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .result_matrix(rm),
      .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_row(m_row), .m_col(m_col), .m_last(m_last), .done(done)
`ifdef RESULT_DRAIN_SAT_EN
      , .sat_seen(sat_seen)
`endif
   );

   task automatic check(input string tag, input longint obs, input longint expv);
      checks++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0 uniform -250, 1 10*r+c, 2 distinct negatives, 3 conversion corners
   task automatic fill(input int kind);
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            case (kind)
               0:       exp_d[r][c] = -250;
               1:       exp_d[r][c] = 10*r + c;
               2:       exp_d[r][c] = -(10*r + c) - 100;
               default: exp_d[r][c] = 0;
            endcase
            rm[r][c] = ACC_W'(exp_d[r][c]);
         end
      end
      if (kind == 3) begin
         rm[0][0] = ACC_W'(40000);
         rm[0][1] = ACC_W'(-40000);
`ifdef RESULT_DRAIN_SAT_EN
         exp_d[0][0] = 32767;
         exp_d[0][1] = -32768;
`else
         exp_d[0][0] = -25536;
         exp_d[0][1] = 25536;
`endif
      end
   endtask

   // 0 full rate, 1 backpressure, 2 snapshot isolation, 3 start while busy, 4 abort after 42
   task automatic run_txn(input int mode);
      int n, hs, dones, done_n, first_v, stall37, idx;
      bit rdy, prev_stall;
      logic signed [OUT_W-1:0] p_data;
      logic [IW-1:0] p_row, p_col;
      logic p_last;
      hs = 0; dones = 0; done_n = -1; first_v = -1; stall37 = 0; prev_stall = 1'b0;
      p_data = '0; p_row = '0; p_col = '0; p_last = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (n < 2000) begin
         if (mode == 4 && hs == 42) begin
            reset = 1'b0;
            #1;
            check("abort_valid", m_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_last", m_last, 0);
            tick();
            tick();
            reset = 1'b1;
            m_ready = 1'b1;
            tick();
            return;
         end
         if (dones > 0 && n == done_n + 1) begin
            check("done_pulse", done, 0);
            check("busy_idle", busy, 0);
            break;
         end
         start = (mode == 3 && (n == 10 || n == 60 || n == LAT + 1 + NEL));
         if (mode == 3 && dones == 0) check("busy_hold", busy, 1);
         if (m_valid && first_v < 0) first_v = n;
         if (first_v > 0 && hs < NEL) check("valid_gap", m_valid, 1);
         if (prev_stall) begin
            check("stall_data", $signed(m_data), $signed(p_data));
            check("stall_row", m_row, p_row);
            check("stall_col", m_col, p_col);
            check("stall_last", m_last, p_last);
         end
         if (done) begin
            dones++;
            done_n = n;
         end
         rdy = 1'b1;
         if (mode == 1) begin
            rdy = 1'($urandom_range(0, 1));
            if (m_valid && m_row == 3 && m_col == 7) rdy = (stall37 >= 5);
         end
         if (m_valid && !rdy && m_row == 3 && m_col == 7) begin
            stall37++;
            check("hold_37", $signed(m_data), 37);
         end
         if (m_valid && rdy) begin
            idx = hs % NEL;
            check("row", m_row, idx / SIZE);
            check("col", m_col, idx % SIZE);
            check("data", $signed(m_data), exp_d[idx / SIZE][idx % SIZE]);
            check("last", m_last, (hs == NEL - 1));
            hs++;
         end
         prev_stall = m_valid && !rdy;
         p_data = m_data; p_row = m_row; p_col = m_col; p_last = m_last;
         m_ready = rdy;
         if (mode == 2 && n == first_v) begin
            for (int r = 0; r < SIZE; r++)
               for (int c = 0; c < SIZE; c++)
                  rm[r][c] = '0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      m_ready = 1'b1;
      check("handshakes", hs, NEL);
      check("done_count", dones, 1);
      if (mode == 0 || mode == 3) begin
         check("first_valid", first_v, LAT + 1);
         check("done_cycle", done_n, LAT + 1 + NEL);
      end
      if (mode == 1) check("stall_37", stall37, 5);
      if (mode == 3) begin
         tick();
         check("start_at_done", busy, 0);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      m_ready = 1'b1;
      fill(0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_done", done, 0);
      check("rst_data", $signed(m_data), 0);
      check("rst_row", m_row, 0);
      check("rst_col", m_col, 0);
      reset = 1'b1;
      tick();

      fill(0); run_txn(0);
`ifdef RESULT_DRAIN_SAT_EN
      check("sat_clear", sat_seen, 0);
`endif
      fill(1); run_txn(1);
      fill(2); run_txn(2);
      fill(0); run_txn(3);
      fill(1); run_txn(4);
      check("post_abort_row", m_row, 0);
      run_txn(0);
      fill(3); run_txn(0);
`ifdef RESULT_DRAIN_SAT_EN
      check("sat_seen", sat_seen, 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Reader end of the systolic array result interface.
- After a start pulse, waits a fixed pipeline latency, then snapshots the array's result_matrix.
- Streams the SIZE*SIZE results out in row-major order over a valid/ready stream, with a coordinate tag on every element.
- Sits between systolic_array and the NPU writeback/DMA path.

Parameters:
- WIDTH, 16, operand width of the systolic array.
- SIZE, 10, array dimension (SIZE x SIZE results).
- ACC_W, 2*WIDTH+$clog2(SIZE)+1, width of each result_matrix element (37 at defaults).
- OUT_W, 16, width of the streamed data word; must satisfy OUT_W <= ACC_W.
- LATENCY, 3*SIZE-2, cycles from start to results valid (28 at defaults).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse: computation launched this cycle
- result_matrix  in  signed [ACC_W-1:0] [0:SIZE-1][0:SIZE-1]  live array outputs
- busy  out  1  high in any state other than IDLE
- m_valid  out  1  stream element valid
- m_ready  in  1  downstream accept
- m_data  out  signed [OUT_W-1:0]  converted result element
- m_row  out  [$clog2(SIZE)-1:0]  row index of m_data
- m_col  out  [$clog2(SIZE)-1:0]  column index of m_data
- m_last  out  1  high with element [SIZE-1][SIZE-1]
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, m_valid, m_last and done = 0; m_data, m_row, m_col = 0; wait counter and snapshot cleared.
- FSM states: IDLE, WAIT, CAPTURE, STREAM, DONE.
- IDLE:
  - start=1 at edge T -> WAIT; wait counter loads LATENCY-1.
  - start is ignored in every other state; no queueing.
- WAIT:
  - Counter decrements once per cycle.
  - At zero -> CAPTURE, so CAPTURE is active during cycle T+LATENCY.
- CAPTURE:
  - At the following edge, all SIZE*SIZE elements are registered into the snapshot.
  - Row and column pointers are set to 0; state -> STREAM.
  - m_valid rises in the same edge, i.e. first valid cycle is T+LATENCY+1.
  - Later changes on result_matrix do not affect the streamed data.
- STREAM:
  - m_data, m_row, m_col and m_last are registered and reflect snapshot[row][col].
  - Handshake occurs when m_valid && m_ready at a rising edge.
  - While m_valid=1 && m_ready=0, all m_* outputs hold stable.
  - On handshake: col++. When col wraps from SIZE-1 to 0, row++.
  - The next element is presented in the next cycle, so full throughput is 1 element/cycle with m_ready held high.
  - m_valid never drops between elements except on reset.
  - m_last=1 only while presenting [SIZE-1][SIZE-1].
  - Handshake with m_last=1 -> DONE; m_valid and m_last drop.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same edge as the return to IDLE.
- Total transfer with m_ready=1 throughout: SIZE*SIZE handshakes; done is high in cycle T+LATENCY+1+SIZE*SIZE.
- Conversion from ACC_W to OUT_W is signed; it is defined under Optional Feature.
- Boundaries:
  - m_ready may be high before m_valid; no handshake occurs without m_valid.
  - m_ready toggling on any cycle is legal.
  - start coincident with DONE is ignored.
  - Reset asserted mid-WAIT or mid-STREAM aborts immediately to the reset values above. No done pulse is issued; the partial stream is discarded by the consumer.

Optional Feature:
- Macro: RESULT_DRAIN_SAT_EN.
- Defined:
  - m_data is the signed saturation of the ACC_W value to OUT_W: values above 2^(OUT_W-1)-1 clamp to that maximum, values below -2^(OUT_W-1) clamp to that minimum.
  - An extra output port sat_seen (1 bit) is added. It is cleared on entry to WAIT and set if any streamed element was clamped; it holds until the next start.
- Not defined:
  - m_data is the low OUT_W bits of the result (two's-complement wrap).
  - Port sat_seen does not exist.
- In both cases, when OUT_W == ACC_W the conversion is the identity.

Test Plan:
- Uniform results, full throughput: weights are rows 0-4 = 1, rows 5-9 = -1; inputs are input[i][j] = 10*i + 10*j; start at T; m_ready=1 throughout. Required:
  - m_valid first high at T+29.
  - 100 elements, all m_data = -250.
  - Row/col sequence goes (0,0),(0,1)…(9,9).
  - m_last only on (9,9).
  - done at T+129.
- Backpressure: drive result_matrix[r][c] = 10*r + c directly and toggle m_ready pseudo-randomly. Required:
  - Every element is seen exactly once with m_data = 10*m_row + m_col.
  - m_* outputs are stable during stalls.
  - Element (3,7) is held for 5 stalled cycles with value 37.
- Snapshot isolation: after the capture edge, overwrite the whole result_matrix with 0 → the stream still delivers the captured values.
- Start ignored while busy: pulse start at T+10 and again at T+60 → exactly one stream of 100 elements and one done pulse; busy stays high continuously from T+1 to T+129.
- Reset mid-stream: assert reset after 42 handshakes. Required:
  - m_valid, busy and done are 0 immediately (asynchronous).
  - After release, a new start yields a complete 100-element stream beginning at (0,0).
- Conversion: set element [0][0] = 40000 and [0][1] = -40000. Required:
  - With RESULT_DRAIN_SAT_EN defined, m_data = 32767 and -32768, and sat_seen = 1 after the stream.
  - Without it, m_data = -25536 and 25536.
